packet_tx_scheduler: RTL and testbench
======================================

PACKET_TX_SCHEDULER -- requirements
Module: packet_tx_scheduler

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 10, clk cycles per serial bit (legal >= 2).
REQ-002 SHALL have parameter GAP_BITS, default 2, idle bit-times forced between frames (legal >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  2  per-requester packet request, level, held until granted.
REQ-006 SHALL have port data0  input  8  payload of requester 0, stable while req[0]=1.
REQ-007 SHALL have port data1  input  8  payload of requester 1, stable while req[1]=1.
REQ-008 SHALL have port err_inj  input  2  bit0 inverts the parity bit; bit1 inverts the stop bit; sampled at grant.
REQ-009 SHALL have port gnt  output  2  one-cycle registered grant pulse, one-hot.
REQ-010 SHALL have port busy  output  1  high from grant cycle through end of gap.
REQ-011 SHALL have port ser_out  output  1  serial line to the receiver; idles high.
REQ-012 SHALL have port done  output  1  one-cycle pulse in the last cycle of the stop bit.

Function
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, GAP.
REQ-014 SHALL, in IDLE with req != 0 at edge N: latch the winner's data and err_inj, update the RR pointer, and enter START; gnt[winner]=1 and ser_out=0 during cycle N+1 only.
REQ-015 SHALL arbitrate round-robin: both requesting -> the requester not granted last wins; a single requester always wins; after reset requester 0 has priority.
REQ-016 SHALL hold each bit on ser_out for exactly BIT_CYCLES cycles, using a cycle counter of ceil(log2(BIT_CYCLES)) bits that wraps to 0 at BIT_CYCLES-1.
REQ-017 SHALL emit the frame: start 0, data bits 7..0 (MSB first), parity, stop 1; 11 bit-times total.
REQ-018 SHALL compute parity = XOR of the 8 latched data bits (even parity), XOR err_inj[0].
REQ-019 SHALL drive the stop bit as 1 XOR err_inj[1].
REQ-020 SHALL drive ser_out=1 for GAP_BITS*BIT_CYCLES cycles in GAP, then enter IDLE; req is ignored outside IDLE.
REQ-021 SHALL start the next frame at the earliest 11*BIT_CYCLES + GAP_BITS*BIT_CYCLES + 1 cycles after the previous gnt.
REQ-022 SHALL grant again if req stays high after gnt, so a requester drops req the cycle after its gnt unless it has another packet.
REQ-023 SHALL ignore changes to data0/data1/err_inj after the latch edge.
REQ-024 SHALL register ser_out, with no combinational path from inputs to ser_out, gnt, or done.

Reset
REQ-025 SHALL, while rst_n=0, immediately force state=IDLE, ser_out=1, gnt=0, busy=0, done=0, counters=0, RR pointer=requester 0.
REQ-026 SHALL abort any in-flight frame on reset with no done pulse; after release, the first frame starts only from a fresh IDLE arbitration.

Verification
REQ-027 SHALL verify single frame: req=01, data0=8'h18 -> gnt=01 for 1 cycle; ser_out = 0,0,0,0,1,1,0,0,0,0,1 per 10-cycle bit; done at cycle 110 after gnt; busy low 20 cycles later.
REQ-028 SHALL verify contention: req=11, data0=8'h34, data1=8'h94 -> frame 1 from requester 0, parity 1; frame 2 from requester 1, parity 1; second gnt 131 cycles after the first.
REQ-029 SHALL verify fairness: req held 11 for 4 frames -> gnt sequence 01,10,01,10.
REQ-030 SHALL verify error injection: data=8'h37 with err_inj=01 -> parity bit 0 (normally 1); with err_inj=10 -> stop bit 0; the next frame with err_inj=00 is clean.
REQ-031 SHALL verify mid-frame reset: rst_n low during data bit 3 -> ser_out=1 asynchronously and no done; after release with req=10, the next frame is intact and granted to requester 1.
REQ-032 SHALL verify a receiver loop-back: 8 frames into the serial receiver -> output bytes equal the payloads in grant order.

Source files
------------

// File: rtl/packet_tx_scheduler.sv
// Two-requester round-robin packet scheduler that serialises one byte per frame
// (start, 8 data bits MSB first, even parity, stop) followed by a forced idle gap.

module packet_tx_scheduler_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [1:0] gnt,
    input logic       busy,
    input logic       ser_out,
    input logic       done
);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_gnt_frame:  assert property (@(posedge clk) disable iff (!rst_n) (gnt != 2'b00) |-> (busy && !ser_out));
    a_done_busy:  assert property (@(posedge clk) disable iff (!rst_n) done |-> busy);

endmodule

module packet_tx_scheduler #(
    parameter int BIT_CYCLES = 10,
    parameter int GAP_BITS   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [1:0] err_inj,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       ser_out,
    output logic       done
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W = ($clog2(GAP_BITS) > 3) ? $clog2(GAP_BITS) : 3;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
    // done is registered, so it is armed one cycle before the last stop cycle
    localparam logic [CNT_W-1:0] CNT_DONE  = CNT_W'(BIT_CYCLES - 2);
    localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(7);
    localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GAP    = 3'd5
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r,   cnt_s;
    logic [IDX_W-1:0] idx_r,   idx_s;
    logic [7:0]       shift_r, shift_s;
    logic             par_r,   par_s;
    logic             stop_r,  stop_s;
    logic             prio_r,  prio_s;
    logic [1:0]       gnt_r,   gnt_s;
    logic             busy_r,  busy_s;
    logic             ser_r,   ser_s;
    logic             done_r,  done_s;

    logic             bit_end_s;
    logic             sel_s;
    logic [7:0]       sel_data_s;

    assign bit_end_s  = (cnt_r == CNT_LAST);
    // single requester always wins; on contention prio_r names the favoured one
    assign sel_s      = (req == 2'b11) ? prio_r : req[1];
    assign sel_data_s = sel_s ? data1 : data0;

    // Next-state, datapath and output computation for the frame sequencer
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        par_s   = par_r;
        stop_s  = stop_r;
        prio_s  = prio_r;
        gnt_s   = 2'b00;
        busy_s  = busy_r;
        ser_s   = ser_r;
        done_s  = 1'b0;

        case (state_r)
            IDLE: begin
                cnt_s  = CNT_ZERO;
                idx_s  = IDX_ZERO;
                ser_s  = 1'b1;
                busy_s = 1'b0;
                if (req != 2'b00) begin
                    state_s = START;
                    gnt_s   = sel_s ? 2'b10 : 2'b01;
                    prio_s  = ~sel_s;
                    shift_s = sel_data_s;
                    par_s   = even_parity(sel_data_s) ^ err_inj[0];
                    stop_s  = 1'b1 ^ err_inj[1];
                    busy_s  = 1'b1;
                    ser_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end

            START: begin
                if (bit_end_s) begin
                    state_s = DATA;
                    cnt_s   = CNT_ZERO;
                    idx_s   = IDX_ZERO;
                    ser_s   = shift_r[7];
                    shift_s = {shift_r[6:0], 1'b0};
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            DATA: begin
                if (bit_end_s) begin
                    cnt_s = CNT_ZERO;
                    if (idx_r == DATA_LAST) begin
                        state_s = PARITY;
                        ser_s   = par_r;
                    end else begin
                        idx_s   = idx_r + IDX_ONE;
                        ser_s   = shift_r[7];
                        shift_s = {shift_r[6:0], 1'b0};
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            PARITY: begin
                if (bit_end_s) begin
                    state_s = STOP;
                    cnt_s   = CNT_ZERO;
                    ser_s   = stop_r;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            STOP: begin
                done_s = (cnt_r == CNT_DONE);
                if (bit_end_s) begin
                    state_s = GAP;
                    cnt_s   = CNT_ZERO;
                    idx_s   = IDX_ZERO;
                    ser_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            GAP: begin
                ser_s = 1'b1;
                if (bit_end_s) begin
                    cnt_s = CNT_ZERO;
                    if (idx_r == GAP_LAST) begin
                        state_s = IDLE;
                        idx_s   = IDX_ZERO;
                        busy_s  = 1'b0;
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
                idx_s   = IDX_ZERO;
                ser_s   = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= IDX_ZERO;
            shift_r <= 8'h00;
            par_r   <= 1'b0;
            stop_r  <= 1'b1;
            prio_r  <= 1'b0;
            gnt_r   <= 2'b00;
            busy_r  <= 1'b0;
            ser_r   <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            par_r   <= par_s;
            stop_r  <= stop_s;
            prio_r  <= prio_s;
            gnt_r   <= gnt_s;
            busy_r  <= busy_s;
            ser_r   <= ser_s;
            done_r  <= done_s;
        end
    end

    assign gnt     = gnt_r;
    assign busy    = busy_r;
    assign ser_out = ser_r;
    assign done    = done_r;

    packet_tx_scheduler_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .gnt     (gnt_r),
        .busy    (busy_r),
        .ser_out (ser_r),
        .done    (done_r)
    );

endmodule

// File: tb/tb_packet_tx_scheduler.sv
// Directed bench for packet_tx_scheduler: contention, fairness, framing, error
// injection, mid-frame reset and a serial receiver loop-back.

module tb_packet_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] err_inj;
    logic [1:0] gnt;
    logic       busy;
    logic       ser_out;
    logic       done;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    packet_tx_scheduler #(.BIT_CYCLES(10), .GAP_BITS(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data0   (data0),
        .data1   (data1),
        .err_inj (err_inj),
        .gnt     (gnt),
        .busy    (busy),
        .ser_out (ser_out),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent serial receiver: detects the start bit and samples mid-bit
    logic       rx_en = 1'b0;
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (!rst_n || !rx_en) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (ser_out === 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if ((rx_cnt % 10) == 4 && rx_cnt >= 14 && rx_cnt <= 84)
                rx_sh <= {rx_sh[6:0], ser_out};
            if (rx_cnt == 104 && ser_out === 1'b1)
                rx_q.push_back(rx_sh);
            if (rx_cnt > 104 && ser_out === 1'b1)
                rx_act <= 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for a grant, then follows the frame for 131 cycles (offset 0 = grant cycle).
    task automatic run_frame(input logic [1:0] clr, input logic [1:0] scr,
                             output logic [1:0] g, output logic [7:0] lat,
                             output logic [10:0] bits, output int gc);
        int   pre_done = 0;
        int   done_off = -1;
        int   done_n   = 0;
        logic busy_ok  = 1'b1;
        logic gap_ok   = 1'b1;
        logic busy_low = 1'b0;
        logic gnt_off1 = 1'b1;
        g    = 2'b00;
        lat  = 8'h00;
        bits = 11'h000;
        gc   = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) break;
            if (done === 1'b1) pre_done++;
        end
        check("gnt_seen", 32'(gnt != 2'b00), 32'd1);
        if (gnt == 2'b00) return;
        g   = gnt;
        gc  = cyc;
        lat = g[1] ? data1 : data0;
        req = req & ~clr;
        if (scr[0]) begin
            if (g[1]) data1 = 8'($urandom);
            else      data0 = 8'($urandom);
        end
        if (scr[1]) err_inj = ~err_inj;
        for (int off = 0; off <= 130; off++) begin
            if ((off % 10) == 4 && off < 110) bits[10 - off / 10] = ser_out;
            if (done === 1'b1) begin
                done_n++;
                if (done_off < 0) done_off = off;
            end
            if (off == 1) gnt_off1 = (gnt === 2'b00);
            if (off < 130 && busy !== 1'b1) busy_ok = 1'b0;
            if (off == 130) busy_low = (busy === 1'b0);
            if (off >= 110 && ser_out !== 1'b1) gap_ok = 1'b0;
            if (off < 130) @(negedge clk);
        end
        check("done_before_gnt", 32'(pre_done), 32'd0);
        check("gnt_one_cycle", 32'(gnt_off1), 32'd1);
        check("done_offset", 32'(done_off), 32'd109);
        check("done_count", 32'(done_n), 32'd1);
        check("busy_hold", 32'(busy_ok), 32'd1);
        check("busy_low_after_gap", 32'(busy_low), 32'd1);
        check("gap_high", 32'(gap_ok), 32'd1);
    endtask

    logic [1:0]  g;
    logic [7:0]  lat;
    logic [10:0] bits;
    int          gc;
    int          gprev;
    logic [7:0]  exp_q[$];

    initial begin
        rst_n   = 1'b0;
        req     = 2'b00;
        data0   = 8'h00;
        data1   = 8'h00;
        err_inj = 2'b00;
        repeat (2) @(negedge clk);
        check("reset_ser_out", 32'(ser_out), 32'd1);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ser_out", 32'(ser_out), 32'd1);

        // contention: both request, requester 0 favoured after reset
        data0 = 8'h34;
        data1 = 8'h94;
        req   = 2'b11;
        run_frame(2'b01, 2'b00, g, lat, bits, gc);
        check("cont_gnt0", 32'(g), 32'h1);
        check("cont_frame0", 32'(bits), 32'h0D3);
        gprev = gc;
        run_frame(2'b10, 2'b00, g, lat, bits, gc);
        check("cont_gnt1", 32'(g), 32'h2);
        check("cont_frame1", 32'(bits), 32'h253);
        check("cont_spacing", 32'(gc - gprev), 32'd131);
        gprev = gc;

        // fairness: req held at 11 for four frames
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_frame((i == 3) ? 2'b11 : 2'b00, 2'b00, g, lat, bits, gc);
            check("fair_gnt", 32'(g), (i % 2 == 1) ? 32'h2 : 32'h1);
            check("fair_frame", 32'(bits), (i % 2 == 1) ? 32'h253 : 32'h0D3);
            check("fair_spacing", 32'(gc - gprev), 32'd131);
            gprev = gc;
        end

        // single frame, payload changed right after the latch edge
        data0 = 8'h18;
        req   = 2'b01;
        run_frame(2'b01, 2'b01, g, lat, bits, gc);
        check("single_gnt", 32'(g), 32'h1);
        check("single_frame", 32'(bits), 32'h061);

        // error injection, err_inj flipped after the latch edge
        data0   = 8'h37;
        err_inj = 2'b01;
        req     = 2'b01;
        run_frame(2'b01, 2'b10, g, lat, bits, gc);
        check("err_parity_frame", 32'(bits), 32'h0DD);
        err_inj = 2'b10;
        req     = 2'b01;
        run_frame(2'b01, 2'b10, g, lat, bits, gc);
        check("err_stop_frame", 32'(bits), 32'h0DE);
        err_inj = 2'b00;
        req     = 2'b01;
        run_frame(2'b01, 2'b00, g, lat, bits, gc);
        check("clean_frame", 32'(bits), 32'h0DF);

        // mid-frame reset during data bit 3 of 8'hA5 (a 0 bit)
        data0 = 8'hA5;
        req   = 2'b01;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) break;
        end
        check("mid_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        repeat (55) @(negedge clk);
        check("mid_pre_reset_ser", 32'(ser_out), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_async_ser", 32'(ser_out), 32'd1);
        check("mid_async_busy", 32'(busy), 32'd0);
        check("mid_async_done", 32'(done), 32'd0);
        req   = 2'b10;
        data1 = 8'h3C;
        repeat (3) @(negedge clk);
        check("mid_reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        run_frame(2'b10, 2'b00, g, lat, bits, gc);
        check("mid_after_gnt", 32'(g), 32'h2);
        check("mid_after_frame", 32'(bits), 32'h0F1);

        // loop-back: eight frames with both requesting, fresh payload after each grant
        rx_en = 1'b1;
        data0 = 8'($urandom);
        data1 = 8'($urandom);
        req   = 2'b11;
        for (int i = 0; i < 8; i++) begin
            run_frame((i == 7) ? 2'b11 : 2'b00, 2'b01, g, lat, bits, gc);
            exp_q.push_back(lat);
            check("loop_frame", 32'(bits), 32'({1'b0, lat, ^lat, 1'b1}));
        end
        repeat (5) @(negedge clk);
        check("loop_rx_count", 32'(rx_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < rx_q.size())
                check("loop_rx_byte", 32'(rx_q[i]), 32'(exp_q[i]));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
